smvm_row_accum: RTL and testbench
=================================

// Module: smvm_row_accum
// PURPOSE
//  Downstream result stage of the SMVM datapath. Accepts signed partial-sum contributions
//  (row index + value) from the reducer/AAC outputs and accumulates them per matrix row.
//  After the last contribution it streams the row results 0..num_rows-1 out, one per cycle.
//  Owns the final out_valid/data_out stream of the accelerator.
// PARAMETERS
//  MAX_ROWS  128  maximum matrix rows held in the accumulation buffer
//  ROW_W     7    width of pp_row, log2(MAX_ROWS)
//  SUM_W     15   width of accumulators, pp_data and data_out (two's complement)
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       pulse: begin new matrix; sampled only in IDLE
//  num_rows   in   8       row count for this matrix, valid 1..128, sampled with start
//  pp_valid   in   1       partial-sum contribution valid
//  pp_ready   out  1       contribution accepted when pp_valid&pp_ready; high only in ACCUM
//  pp_row     in   ROW_W   destination row of contribution
//  pp_data    in   SUM_W   signed contribution
//  pp_last    in   1       qualifies final contribution of the matrix (with pp_valid)
//  out_valid  out  1       data_out carries a row result
//  data_out   out  SUM_W   signed row result
//  out_last   out  1       high with out_valid on row num_rows-1
//  busy       out  1       high in every state except IDLE
//  err        out  1       sticky: out-of-range pp_row seen; cleared by rst or accepted start
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, out_last, pp_ready, busy, err = 0; data_out = 0;
//   row/clear/drain pointers = 0. Buffer contents undefined (always cleared before use).
//  FSM: IDLE -> CLEAR -> ACCUM -> DRAIN -> IDLE.
//   IDLE : start && num_rows in 1..128 -> latch num_rows, clear err, go CLEAR.
//          start && num_rows==0 or >128 -> ignored, remain IDLE, err set.
//   CLEAR: writes 0 to buf[clr_ptr], clr_ptr 0..num_rows-1, one row/cycle (num_rows cycles);
//          pp_ready=0; after row num_rows-1 -> ACCUM.
//   ACCUM: pp_ready=1. On handshake: if pp_row<num_rows, buf[pp_row] <= buf[pp_row]+pp_data
//          (single-cycle read-modify-write, result truncated to SUM_W, wraps mod 2^SUM_W,
//          no saturation); else contribution dropped, err<=1.
//          Back-to-back handshakes to the same row every cycle must all be counted.
//          Handshake with pp_last=1 still accumulates its data, then -> DRAIN.
//          pp_last without pp_valid has no effect.
//   DRAIN: drain ptr 0..num_rows-1; registered output: out_valid/data_out=buf[ptr] appear
//          the cycle after ptr is presented. First out_valid on the 2nd rising edge after
//          the pp_last handshake edge; exactly num_rows consecutive out_valid cycles, no gaps,
//          no backpressure. out_last with the final word; next cycle out_valid=0, IDLE.
//  start outside IDLE is ignored (no effect on state, num_rows or err).
//  pp_valid outside ACCUM is ignored (pp_ready=0, no accumulation, no err).
//  rst asserted in any state: immediately returns to reset values; partial matrix discarded;
//   a subsequent start runs a full CLEAR so no stale sums leak out.
//  busy=1 from the edge that leaves IDLE until the edge that returns to IDLE.
// STRUCTURE
//  smvm_pkg: state encoding (IDLE/CLEAR/ACCUM/DRAIN), MAX_ROWS, ROW_W, SUM_W shared with SMVM.
//  One sub-module: smvm_row_regfile - MAX_ROWS x SUM_W flop array, one write port
//   (clear or accumulate), one combinational read port for RMW, one for drain.
//  FSM, pointers, range check and output registers stay in smvm_row_accum.
// TESTING
//  1 rst pulse mid-idle -> out_valid=0, out_last=0, pp_ready=0, busy=0, err=0, data_out=0.
//  2 start num_rows=3; pp_ready low 3 cycles; (0,5),(2,-3),(0,7,last) -> data_out 12, 0,
//    0x7FFD over 3 consecutive cycles, out_last on the 3rd, then busy=0.
//  3 num_rows=1; (0,16383),(0,16383,last) -> single output 0x7FFE (wrap to -2).
//  4 num_rows=4; (5,9) then (1,2,last) -> err=1, outputs 0,2,0,0; err cleared by next start.
//  5 num_rows=2; pp_row=1,data=1 on 4 consecutive cycles, last on 4th -> outputs 0,4.
//  6 rst asserted during DRAIN of row 1 of 3 -> out_valid=0 immediately; new start
//    num_rows=2, (1,1,last) -> outputs 0,1 (no stale data); start num_rows=0 -> err=1, IDLE.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared SMVM types and widths: FSM encoding of the row accumulator and buffer geometry.
package smvm_pkg;

  localparam int unsigned MAX_ROWS = 128;
  localparam int unsigned ROW_W    = $clog2(MAX_ROWS);
  localparam int unsigned SUM_W    = 15;
  localparam int unsigned NR_W     = ROW_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DRAIN = 2'd3
  } acc_state_e;

  // Row count accepted by start: 1..MAX_ROWS.
  function automatic logic num_rows_ok(input logic [NR_W-1:0] n);
    return (n != '0) && (n <= NR_W'(MAX_ROWS));
  endfunction

  // Row index falls inside the matrix currently being accumulated.
  function automatic logic row_in_range(input logic [ROW_W-1:0] row,
                                        input logic [NR_W-1:0]  n);
    return {1'b0, row} < n;
  endfunction

  // Pointer sits on the final row of the matrix.
  function automatic logic is_last_row(input logic [ROW_W-1:0] ptr,
                                       input logic [NR_W-1:0]  n);
    return {1'b0, ptr} == (n - NR_W'(1));
  endfunction

endpackage

// File: rtl/smvm_row_regfile.sv
// Per-row accumulation buffer: one write port, one RMW read port, one drain read port.
module smvm_row_regfile
  import smvm_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [ROW_W-1:0] waddr_i,
  input  logic [SUM_W-1:0] wdata_i,
  input  logic [ROW_W-1:0] rmw_addr_i,
  output logic [SUM_W-1:0] rmw_data_o,
  input  logic [ROW_W-1:0] drn_addr_i,
  output logic [SUM_W-1:0] drn_data_o
);

  // Contents are undefined after reset; every matrix clears its rows before use.
  logic [SUM_W-1:0] mem_q [MAX_ROWS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rmw_data_o = mem_q[rmw_addr_i];
  assign drn_data_o = mem_q[drn_addr_i];

endmodule

// File: rtl/smvm_row_accum.sv
// SMVM result stage: accumulates signed per-row contributions, then streams the row sums out.
module smvm_row_accum
  import smvm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NR_W-1:0]  num_rows,
  input  logic             pp_valid,
  output logic             pp_ready,
  input  logic [ROW_W-1:0] pp_row,
  input  logic [SUM_W-1:0] pp_data,
  input  logic             pp_last,
  output logic             out_valid,
  output logic [SUM_W-1:0] data_out,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  acc_state_e       state_q, state_d;
  logic [NR_W-1:0]  num_rows_q, num_rows_d;
  logic [ROW_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ROW_W-1:0] drn_ptr_q, drn_ptr_d;
  logic             err_q, err_d;
  logic             pp_ready_q, pp_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [SUM_W-1:0] data_out_q, data_out_d;

  logic             we_c;
  logic [ROW_W-1:0] waddr_c;
  logic [SUM_W-1:0] wdata_c;
  logic [SUM_W-1:0] rmw_data_c;
  logic [SUM_W-1:0] drn_data_c;
  logic             pp_fire_c;

  smvm_row_regfile u_regfile (
    .clk        (clk),
    .we_i       (we_c),
    .waddr_i    (waddr_c),
    .wdata_i    (wdata_c),
    .rmw_addr_i (pp_row),
    .rmw_data_o (rmw_data_c),
    .drn_addr_i (drn_ptr_q),
    .drn_data_o (drn_data_c)
  );

  // pp_ready_q is high exactly while in ACCUM, so it also qualifies the handshake.
  assign pp_fire_c = pp_valid & pp_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_rows_q  <= '0;
      clr_ptr_q   <= '0;
      drn_ptr_q   <= '0;
      err_q       <= 1'b0;
      pp_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      clr_ptr_q   <= clr_ptr_d;
      drn_ptr_q   <= drn_ptr_d;
      err_q       <= err_d;
      pp_ready_q  <= pp_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      data_out_q  <= data_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_rows_d  = num_rows_q;
    clr_ptr_d   = clr_ptr_q;
    drn_ptr_d   = drn_ptr_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    data_out_d  = data_out_q;
    we_c        = 1'b0;
    waddr_c     = '0;
    wdata_c     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_rows_ok(num_rows)) begin
            num_rows_d = num_rows;
            err_d      = 1'b0;
            clr_ptr_d  = '0;
            state_d    = ST_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        we_c    = 1'b1;
        waddr_c = clr_ptr_q;
        if (is_last_row(clr_ptr_q, num_rows_q)) begin
          clr_ptr_d = '0;
          state_d   = ST_ACCUM;
        end else begin
          clr_ptr_d = ROW_W'(clr_ptr_q + ROW_W'(1));
        end
      end

      // Single-cycle RMW; back-to-back hits on one row see the previous write via the flops.
      ST_ACCUM: begin
        if (pp_fire_c) begin
          if (row_in_range(pp_row, num_rows_q)) begin
            we_c    = 1'b1;
            waddr_c = pp_row;
            wdata_c = SUM_W'(rmw_data_c + pp_data);
          end else begin
            err_d = 1'b1;
          end
          if (pp_last) begin
            drn_ptr_d = '0;
            state_d   = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        out_valid_d = 1'b1;
        data_out_d  = drn_data_c;
        if (is_last_row(drn_ptr_q, num_rows_q)) begin
          out_last_d = 1'b1;
          drn_ptr_d  = '0;
          state_d    = ST_IDLE;
        end else begin
          drn_ptr_d = ROW_W'(drn_ptr_q + ROW_W'(1));
        end
      end

      default: state_d = ST_IDLE;
    endcase

    pp_ready_d = (state_d == ST_ACCUM);
    busy_d     = (state_d != ST_IDLE);
  end

  assign pp_ready  = pp_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_smvm_row_accum.sv
// Scoreboard bench for smvm_row_accum: a row model pushes expected results, a monitor pops them.
module tb_smvm_row_accum;
  import smvm_pkg::*;

  logic             clk;
  logic             rst;
  logic             start;
  logic [NR_W-1:0]  num_rows;
  logic             pp_valid;
  logic             pp_ready;
  logic [ROW_W-1:0] pp_row;
  logic [SUM_W-1:0] pp_data;
  logic             pp_last;
  logic             out_valid;
  logic [SUM_W-1:0] data_out;
  logic             out_last;
  logic             busy;
  logic             err;

  smvm_row_accum dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_rows  (num_rows),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp_row    (pp_row),
    .pp_data   (pp_data),
    .pp_last   (pp_last),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: per-row sums modulo 2^SUM_W and expected {last, data} words.
  int            mdl_acc [MAX_ROWS];
  int            mdl_rows;
  logic [15:0]   sb [$];

  always @(negedge clk) begin
    logic [15:0] e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("extra_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(e[14:0]));
        chk("out_last", 32'(out_last), 32'(e[15]));
      end
    end
  end

  task automatic do_start(input int n);
    start    = 1'b1;
    num_rows = NR_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    mdl_rows = n;
    for (int i = 0; i < MAX_ROWS; i++) mdl_acc[i] = 0;
    chk("start_err_clr", 32'(err), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic send(input int row, input int data, input bit last);
    int waited = 0;
    pp_valid = 1'b1;
    pp_row   = ROW_W'(row);
    pp_data  = SUM_W'(data);
    pp_last  = last;
    while (!pp_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!pp_ready) begin
      chk("pp_ready_timeout", 32'(pp_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      if (row < mdl_rows) mdl_acc[row] = (mdl_acc[row] + data) & 32'h7FFF;
      if (last) begin
        for (int i = 0; i < mdl_rows; i++)
          sb.push_back({(i == mdl_rows - 1), 15'(mdl_acc[i])});
      end
    end
    pp_valid = 1'b0;
    pp_last  = 1'b0;
  endtask

  // Called right after the pp_last handshake edge; checks drain latency and length.
  task automatic drain_check(input int n);
    @(negedge clk);
    chk("drain_latency", 32'(out_valid), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("drain_valid", 32'(out_valid), 32'd1);
      if (i == n - 1) chk("drain_busy_end", 32'(busy), 32'd0);
    end
    @(negedge clk);
    chk("drain_done", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_rows = '0;
    pp_valid = 1'b0; pp_row = '0; pp_data = '0; pp_last = 1'b0;
    mdl_rows = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset pulse while idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_pp_ready",  32'(pp_ready),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 2: three rows, clear phase holds pp_ready low for num_rows cycles
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clear_pp_ready", 32'(pp_ready), 32'd0);
    end
    @(negedge clk);
    chk("accum_pp_ready", 32'(pp_ready), 32'd1);
    send(0, 5, 1'b0);
    send(2, -3, 1'b0);
    send(0, 7, 1'b1);
    drain_check(3);

    // 3: wrap-around of a single row
    do_start(1);
    send(0, 16383, 1'b0);
    send(0, 16383, 1'b1);
    drain_check(1);

    // 4: out-of-range row sets sticky err, contribution dropped
    do_start(4);
    send(5, 9, 1'b0);
    send(1, 2, 1'b1);
    drain_check(4);
    chk("err_sticky", 32'(err), 32'd1);

    // 5: back-to-back hits on the same row
    do_start(2);
    for (int i = 0; i < 4; i++) send(1, 1, (i == 3));
    drain_check(2);

    // 6: reset mid-drain, then a fresh matrix shows no stale sums
    do_start(3);
    send(0, 4, 1'b0);
    send(1, 5, 1'b0);
    send(2, 6, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_start(2);
    send(1, 1, 1'b1);
    drain_check(2);

    start = 1'b1; num_rows = '0;
    @(posedge clk);
    #1 start = 1'b0;
    chk("bad_start_err",  32'(err),  32'd1);
    chk("bad_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("bad_start_ready", 32'(pp_ready), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
